// File: rtl/multiplier_share_scheduler.sv
// rtl/multiplier_share_scheduler.sv - round-robin shared pipelined multiplier with per-requester result slots
// Optional statistics counters when MULTIPLIER_SHARE_STATS_EN is defined.
module multiplier_share_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int INPUT_WIDTH = 8,
    parameter int LATENCY     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]       req_a,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]       req_b,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic [NUM_REQ*2*INPUT_WIDTH-1:0]     resp_product
`ifdef MULTIPLIER_SHARE_STATS_EN
    ,
    output logic [31:0]                          stat_issue_cnt,
    output logic [31:0]                          stat_conflict_cnt
`endif
);

    localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH;
    localparam int TAG_W        = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      busy;
    logic [NUM_REQ-1:0]      elig;
    logic [TAG_W-1:0]        rr;
    logic [TAG_W-1:0]        win;
    logic                    found;
    int                      idx;
    logic [INPUT_WIDTH-1:0]  win_a;
    logic [INPUT_WIDTH-1:0]  win_b;

    logic [LATENCY-1:0]      pipe_valid;
    logic [TAG_W-1:0]        pipe_tag  [LATENCY];
    logic [OUTPUT_WIDTH-1:0] pipe_prod [LATENCY];

    logic [NUM_REQ-1:0]      wb_hit;
    logic [NUM_REQ-1:0]      slot_valid;
    logic [OUTPUT_WIDTH-1:0] slot_prod [NUM_REQ];

    assign elig = req_valid & ~busy;

    // First eligible requester at or after rr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) req_ready[win] = 1'b1;
    end

    assign win_a = req_a[int'(win)*INPUT_WIDTH +: INPUT_WIDTH];
    assign win_b = req_b[int'(win)*INPUT_WIDTH +: INPUT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= found;
            for (int s = 1; s < LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
        end
    end

    // Data stages carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        pipe_tag[0]  <= win;
        pipe_prod[0] <= OUTPUT_WIDTH'(win_a) * OUTPUT_WIDTH'(win_b);
        for (int s = 1; s < LATENCY; s++) begin
            pipe_tag[s]  <= pipe_tag[s-1];
            pipe_prod[s] <= pipe_prod[s-1];
        end
    end

    // The last stage is presented directly so results show LATENCY cycles after issue.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_slot
            assign wb_hit[g] = pipe_valid[LATENCY-1] && (pipe_tag[LATENCY-1] == TAG_W'(g));
            assign resp_product[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
                wb_hit[g] ? pipe_prod[LATENCY-1] : slot_prod[g];
        end
    endgenerate

    assign resp_valid = slot_valid | wb_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            rr         <= '0;
            slot_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_prod[i] <= '0;
        end else begin
            if (found) rr <= (win == TAG_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wb_hit[i]) begin
                    slot_prod[i]  <= pipe_prod[LATENCY-1];
                    slot_valid[i] <= ~resp_ready[i];
                end else if (resp_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
                if (req_ready[i])
                    busy[i] <= 1'b1;
                else if (resp_valid[i] && resp_ready[i])
                    busy[i] <= 1'b0;
            end
        end
    end

`ifdef MULTIPLIER_SHARE_STATS_EN
    int elig_cnt;

    always_comb begin
        elig_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) elig_cnt = elig_cnt + int'(elig[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_cnt    <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (found)         stat_issue_cnt    <= stat_issue_cnt + 32'd1;
            if (elig_cnt >= 2) stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_share_scheduler.sv
// tb/tb_multiplier_share_scheduler.sv - scoreboard bench for multiplier_share_scheduler
module tb_multiplier_share_scheduler;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int L  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*IW-1:0] req_a, req_b;
    logic [N*OW-1:0] resp_product;
`ifdef MULTIPLIER_SHARE_STATS_EN
    logic [31:0]     stat_issue_cnt, stat_conflict_cnt;
`endif

    multiplier_share_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(IW), .LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product)
`ifdef MULTIPLIER_SHARE_STATS_EN
        ,
        .stat_issue_cnt    (stat_issue_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] seen;
    logic [N-1:0] mbusy;
    int           cyc;
    int           vectors;
    int           miscompares;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*IW +: IW] = a;
        req_b[i*IW +: IW] = b;
    endtask

    // Observe one cycle at the falling edge and update the reference model.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            seen  = '0;
            mbusy = '0;
            return;
        end
        check_eq("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        check_eq("ready_legal", 64'(req_ready & ~(req_valid & ~mbusy)), 64'd0);
        for (int i = 0; i < N; i++) begin
            if (resp_valid[i] && !seen[i]) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", 64'(i), 64'd99);
                end else begin
                    e = sb.pop_front();
                    check_eq("resp_tag", 64'(i), 64'(e.tag));
                    check_eq("resp_prod", 64'(resp_product[i*OW +: OW]), 64'(e.prod));
                    check_eq("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
                seen[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
                seen[i]  = 1'b0;
                mbusy[i] = 1'b0;
            end
            if (req_valid[i] && req_ready[i]) begin
                e.tag  = i;
                e.prod = 16'(req_a[i*IW +: IW]) * 16'(req_b[i*IW +: IW]);
                e.cyc  = cyc + L;
                sb.push_back(e);
                mbusy[i] = 1'b1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = '1;
        repeat (L + 3) step();
        resp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    int           cnt;
    logic [N-1:0] granted;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        seen = '0; mbusy = '0;
        req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
        #1;
        do_reset();

        sample();
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_product", 64'(resp_product), 64'd0);
        advance();

        // Single op on requester 0
        set_op(0, 8'd3, 8'd5);
        req_valid = 4'b0001;
        sample();
        check_eq("t1_ready", 64'(req_ready), 64'b0001);
        advance();
        req_valid = '0;
        step(); step();
        sample();
        check_eq("t1_resp_valid", 64'(resp_valid), 64'b0001);
        check_eq("t1_product", 64'(resp_product[0 +: OW]), 64'd15);
        advance();
        sample();
        check_eq("t1_hold", 64'(resp_valid), 64'b0001);
        advance();
        resp_ready = 4'b0001;
        step();
        resp_ready = '0;
        sample();
        check_eq("t1_consumed", 64'(resp_valid), 64'd0);
        advance();

        // Contention from rr=0
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'(i + 2), 8'(10 * i + 1));
        req_valid = '1;
        for (int k = 0; k < N; k++) begin
            sample();
            check_eq("t2_grant", 64'(req_ready), 64'(1 << k));
            if (k == 3) check_eq("t2_first_result", 64'(resp_valid), 64'b0001);
            advance();
        end
        req_valid = '0;
`ifdef MULTIPLIER_SHARE_STATS_EN
        check_eq("t2_conflicts", 64'(stat_conflict_cnt), 64'd3);
        check_eq("t2_issues", 64'(stat_issue_cnt), 64'd4);
`endif
        drain();

        // Busy requester is not granted again until its result is consumed
        set_op(0, 8'd4, 8'd4);
        req_valid = 4'b0001;
        cnt = 0;
        repeat (10) begin
            sample();
            cnt += int'(req_ready[0]);
            advance();
        end
        check_eq("t3_single_grant", 64'(cnt), 64'd1);
        resp_ready = 4'b0001;
        sample();
        check_eq("t3_no_grant_at_ack", 64'(req_ready[0]), 64'd0);
        advance();
        resp_ready = '0;
        sample();
        check_eq("t3_regrant", 64'(req_ready[0]), 64'd1);
        advance();
        drain();

        // Operand extremes
        set_op(2, 8'd255, 8'd255);
        req_valid = 4'b0100;
        sample();
        check_eq("t4_ready_max", 64'(req_ready), 64'b0100);
        advance();
        req_valid = '0;
        step(); step();
        sample();
        check_eq("t4_max_product", 64'(resp_product[2*OW +: OW]), 64'hFE01);
        advance();
        drain();
        set_op(1, 8'd0, 8'd200);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step(); step();
        sample();
        check_eq("t4_zero_product", 64'(resp_product[1*OW +: OW]), 64'd0);
        advance();
        drain();

        // Pointer wrap: grant 3 then 0 ahead of 1
        set_op(3, 8'd9, 8'd9);
        req_valid = 4'b1000;
        sample();
        check_eq("t4_wrap_grant3", 64'(req_ready), 64'b1000);
        advance();
        set_op(0, 8'd6, 8'd7);
        set_op(1, 8'd8, 8'd2);
        req_valid = 4'b0011;
        sample();
        check_eq("t4_wrap_grant0", 64'(req_ready), 64'b0001);
        advance();
        drain();

        // Reset while an op is in flight
        set_op(1, 8'd7, 8'd9);
        req_valid = 4'b0010;
        sample();
        check_eq("t5_issue", 64'(req_ready), 64'b0010);
        advance();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check_eq("t5_regrant", 64'(req_ready), 64'b0010);
        check_eq("t5_no_resp0", 64'(resp_valid), 64'd0);
        check_eq("t5_prod_cleared", 64'(resp_product), 64'd0);
        advance();
        req_valid = '0;
        repeat (2) begin
            sample();
            check_eq("t5_no_resp", 64'(resp_valid), 64'd0);
            advance();
        end
        drain();

        // Random soak against the scoreboard
        granted = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (granted[i] || !req_valid[i] || ($urandom_range(0, 15) == 0)) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, 8'($urandom), 8'($urandom));
                end
            end
            resp_ready = 4'($urandom);
            sample();
            granted = req_valid & req_ready;
            advance();
        end
        drain();
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
